unibus_dma_master: RTL
======================

UNIBUS_DMA_MASTER -- requirements
Module: unibus_dma_master

Interface
REQ-001 Parameter DESKEW, default 8: clock cycles between address/data valid and msyn assertion.
REQ-002 Parameter TIMEOUT, default 1000: clock cycles allowed for grant or ssyn before the cycle aborts.
REQ-003 CLOCK  in  1  sole clock; all state changes on rising edge.
REQ-004 RESET  in  1  asynchronous, active-low reset.
REQ-005 armwrite in 1; armwaddr in 3; armwdata in 32; armraddr in 3; armrdata out 32 (combinational): ARM register access.
REQ-006 armintrq  out  1  high while done bit is set.
REQ-007 npr_out_h out 1; npg_in_h in 1; sack_out_h out 1; bbsy_in_h in 1; bbsy_out_h out 1: bus arbitration.
REQ-008 a_out_h out 18; c_out_h out 2; d_out_h out 16; msyn_out_h out 1; d_in_h in 16; ssyn_in_h in 1; init_in_h in 1: data transfer.

Function
REQ-009 ARM reg 0 SHALL read 32'h444D100A; regs 6-7 read 32'hDEADBEEF.
REQ-010 Reg 1: [31] busy (write 1 = start), [30] timeout error, [29] done, [19:18] c code, [17:00] address; done and error write-1-to-clear.
REQ-011 Reg 2: [31:16] data read by last DATI (read only), [15:00] data to write.
REQ-012 Start while busy SHALL be ignored; start while idle SHALL latch address, c code, write data, clear done/error, set busy, enter REQ next cycle.
REQ-013 States: IDLE, REQ, GRANT, ADDR, MSYN, DATA, RELEASE.
REQ-014 REQ: npr_out_h=1; advance to GRANT when npg_in_h=1 and bbsy_in_h=0 and ssyn_in_h=0.
REQ-015 GRANT: sack_out_h=1, npr_out_h=0; on npg_in_h=0 set bbsy_out_h=1, drive a/c (and d if c[1]=1), enter ADDR.
REQ-016 ADDR: hold outputs DESKEW cycles, then msyn_out_h=1, enter MSYN.
REQ-017 MSYN: on ssyn_in_h=1 capture d_in_h into reg 2 [31:16] if c[1]=0, drop msyn_out_h, enter DATA.
REQ-018 DATA: on ssyn_in_h=0 enter RELEASE.
REQ-019 RELEASE (one cycle): bbsy, sack, a, c, d driven 0; busy=0, done=1; next IDLE.
REQ-020 Timeout counter SHALL reset on each entry to REQ and MSYN; reaching TIMEOUT in REQ, MSYN or DATA sets error=1 and goes to RELEASE.
REQ-021 Byte write (c=2'b11) SHALL drive d_out_h unmodified; byte lane selection belongs to the slave via a_out_h[0].
REQ-022 init_in_h=1 in any non-IDLE state SHALL abort: all bus outputs 0 that cycle, error=1, done=1, busy=0, state IDLE.
REQ-023 armwrite and a state transition in the same cycle: ARM write-1-to-clear and the state machine's done set coincide -> done set wins.
REQ-024 msyn_out_h SHALL never be 1 unless bbsy_out_h=1 and a/c outputs were stable for ≥DESKEW cycles.

Reset
REQ-025 RESET=0 SHALL asynchronously force state IDLE, busy/done/error 0, all bus outputs 0, latched address/data 0.
REQ-026 After RESET=1, first start SHALL be accepted on the next armwrite.

Verification
REQ-027 DATI: addr 18'o001000, c=0, slave returns 16'o123456 -> reg 2 [31:16]=16'o123456, done=1, armintrq=1, error=0.
REQ-028 DATO: addr 18'o774400, data 16'o000004, c=2'b10 -> d_out_h=16'o000004 with msyn high ≥DESKEW cycles after address valid.
REQ-029 No npg ever -> npr held TIMEOUT cycles, then error=1, done=1, npr/sack/bbsy=0.
REQ-030 ssyn never asserted -> msyn drops after TIMEOUT cycles, error=1, bus released.
REQ-031 init_in_h pulse during MSYN -> msyn/bbsy/sack 0 next cycle, error=1, busy=0.
REQ-032 Second start while busy -> ignored; latched address unchanged; exactly one bus cycle observed.

Source files
------------

// File: rtl/unibus_dma_master.sv
// Unibus NPR DMA master: ARM-side registers launch one DATI/DATO bus cycle
// with bus arbitration, address-to-msyn deskew and grant/ssyn timeouts.
module unibus_dma_master #(
  parameter int DESKEW  = 8,
  parameter int TIMEOUT = 1000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        armwrite,
  input  logic [2:0]  armwaddr,
  input  logic [31:0] armwdata,
  input  logic [2:0]  armraddr,
  output logic [31:0] armrdata,
  output logic        armintrq,
  output logic        npr_out_h,
  input  logic        npg_in_h,
  output logic        sack_out_h,
  input  logic        bbsy_in_h,
  output logic        bbsy_out_h,
  output logic [17:0] a_out_h,
  output logic [1:0]  c_out_h,
  output logic [15:0] d_out_h,
  output logic        msyn_out_h,
  input  logic [15:0] d_in_h,
  input  logic        ssyn_in_h,
  input  logic        init_in_h,
  output logic [2:0]  dbg_state
);
  typedef enum logic [2:0] {IDLE, REQ, GRANT, ADDR, MSYN, DATA, RELEASE} state_t;

  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  localparam logic [31:0] DS_LAST = 32'(DESKEW - 1);

  state_t      state;
  logic [31:0] cnt;
  logic        done, err;
  logic [17:0] addr_q;
  logic [1:0]  c_q;
  logic [15:0] wdata_q, wlat_q, rdata_q;
  logic        busy, start, timed_out, grant_ok, abort, to_release;
  logic        unused_bits;

  assign busy        = (state != IDLE);
  assign start       = armwrite && (armwaddr == 3'd1) && armwdata[31] && !busy;
  assign timed_out   = (cnt >= TO_LAST);
  assign grant_ok    = npg_in_h && !bbsy_in_h && !ssyn_in_h;
  assign abort       = init_in_h && busy;
  assign armintrq    = done;
  assign dbg_state   = state;
  assign unused_bits = ^armwdata[28:20];

  // Every path into RELEASE drops the bus on the same edge.
  always_comb begin
    to_release = 1'b0;
    case (state)
      REQ:     to_release = !grant_ok && timed_out;
      MSYN:    to_release = !ssyn_in_h && timed_out;
      DATA:    to_release = 1'b1 && (!ssyn_in_h || timed_out);
      default: to_release = 1'b0;
    endcase
  end

  always_comb begin
    armrdata = 32'h0;
    case (armraddr)
      3'd0:       armrdata = 32'h444D100A;
      3'd1:       armrdata = {busy, err, done, 9'd0, c_q, addr_q};
      3'd2:       armrdata = {rdata_q, wdata_q};
      3'd6, 3'd7: armrdata = 32'hDEADBEEF;
      default:    armrdata = 32'h0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      cnt        <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      addr_q     <= '0;
      c_q        <= '0;
      wdata_q    <= '0;
      wlat_q     <= '0;
      rdata_q    <= '0;
      npr_out_h  <= 1'b0;
      sack_out_h <= 1'b0;
      bbsy_out_h <= 1'b0;
      a_out_h    <= '0;
      c_out_h    <= '0;
      d_out_h    <= '0;
      msyn_out_h <= 1'b0;
    end else begin
      if (armwrite && armwaddr == 3'd2) wdata_q <= armwdata[15:0];
      // ARM clears come first so a same-cycle done set from the FSM wins.
      if (armwrite && armwaddr == 3'd1) begin
        if (armwdata[29]) done <= 1'b0;
        if (armwdata[30]) err  <= 1'b0;
      end
      if (abort) begin
        state <= IDLE;
        err   <= 1'b1;
        done  <= 1'b1;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (start) begin
            addr_q    <= armwdata[17:0];
            c_q       <= armwdata[19:18];
            wlat_q    <= wdata_q;
            done      <= 1'b0;
            err       <= 1'b0;
            cnt       <= '0;
            npr_out_h <= 1'b1;
            state     <= REQ;
          end
          REQ: if (grant_ok) begin
            npr_out_h  <= 1'b0;
            sack_out_h <= 1'b1;
            state      <= GRANT;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= RELEASE;
          end else cnt <= cnt + 32'd1;
          GRANT: if (!npg_in_h) begin
            bbsy_out_h <= 1'b1;
            a_out_h    <= addr_q;
            c_out_h    <= c_q;
            d_out_h    <= c_q[1] ? wlat_q : 16'h0;
            cnt        <= '0;
            state      <= ADDR;
          end
          ADDR: if (cnt >= DS_LAST) begin
            msyn_out_h <= 1'b1;
            cnt        <= '0;
            state      <= MSYN;
          end else cnt <= cnt + 32'd1;
          MSYN: if (ssyn_in_h) begin
            if (!c_q[1]) rdata_q <= d_in_h;
            msyn_out_h <= 1'b0;
            cnt        <= cnt + 32'd1;
            state      <= DATA;
          end else if (timed_out) begin
            err   <= 1'b1;
            state <= RELEASE;
          end else cnt <= cnt + 32'd1;
          DATA: if (!ssyn_in_h) state <= RELEASE;
          else if (timed_out) begin
            err   <= 1'b1;
            state <= RELEASE;
          end else cnt <= cnt + 32'd1;
          RELEASE: begin
            done  <= 1'b1;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
      if (abort || to_release) begin
        npr_out_h  <= 1'b0;
        sack_out_h <= 1'b0;
        bbsy_out_h <= 1'b0;
        a_out_h    <= '0;
        c_out_h    <= '0;
        d_out_h    <= '0;
        msyn_out_h <= 1'b0;
      end
    end
  end
endmodule
